// File: rtl/tlc_pkg.sv
// Shared state encodings and lamp patterns for the traffic-light controller.
package tlc_pkg;

  // PHASE output carries these encodings directly
  typedef enum logic [2:0] {
    ST_HG  = 3'd0,
    ST_HY  = 3'd1,
    ST_AR1 = 3'd2,
    ST_LG  = 3'd3,
    ST_LY  = 3'd4,
    ST_AR2 = 3'd5,
    ST_FL  = 3'd6
  } tlc_state_e;

  // Lamp bundles are {R,Y,G}
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/tlc_tick_gen.sv
// Timing-tick prescaler: TICK is high for one CLK every CLK_DIV cycles.
module tlc_tick_gen #(
  parameter int unsigned CLK_DIV = 100000000
) (
  input  logic CLK,
  input  logic RST_N,
  output logic TICK
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;

  // Free-running divider counting 0..CLK_DIV-1
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                r_div <= '0;
    else if (r_div == DIV_LAST) r_div <= '0;
    else                        r_div <= r_div + DIV_W'(1);
  end

  assign TICK = (r_div == DIV_LAST);

endmodule

// File: rtl/tlc_param_ctrl.sv
// Parametrised two-road traffic-light controller with pedestrian WALK
// and flash mode; all sequencing advances on the prescaled tick.
module tlc_param_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 100000000,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_HG_MIN = 5,
  parameter int unsigned T_Y      = 3,
  parameter int unsigned T_AR     = 1,
  parameter int unsigned T_LG_MIN = 2,
  parameter int unsigned T_LG_MAX = 5,
  parameter int unsigned T_WALK   = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LTV,
  input  logic       PED_REQ,
  input  logic       FLASH,
  output logic [2:0] H,
  output logic [2:0] L,
  output logic       WALK,
  output logic [2:0] PHASE,
  output logic       TICK
);

  // Timer values seen on the tick that ends each timed phase
  localparam logic [CNT_W-1:0] HG_LAST    = CNT_W'(T_HG_MIN - 1);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(T_Y - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(T_AR - 1);
  localparam logic [CNT_W-1:0] LGMIN_LAST = CNT_W'(T_LG_MIN - 1);
  localparam logic [CNT_W-1:0] LGMAX_LAST = CNT_W'(T_LG_MAX - 1);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] WALK_LEN   = CNT_W'(T_WALK);
  localparam logic [CNT_W-1:0] TMR_MAX    = '1;

  logic             w_tick;
  tlc_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic             r_ped_pend, r_ped_served;
  logic             r_blink, w_blink_nxt;
  logic [2:0]       r_h, r_l, w_h_nxt, w_l_nxt;
  logic             w_walk, w_walk_done, w_lg_entry;

  tlc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .TICK  (w_tick)
  );

  // WALK covers the first T_WALK ticks of a local green that served a request;
  // the walk interval is complete on the tick where its last tick elapses.
  assign w_walk      = (r_state == ST_LG) && r_ped_served && (r_timer < WALK_LEN);
  assign w_walk_done = !r_ped_served || (r_timer >= WALK_LAST);
  assign w_lg_entry  = w_tick && (w_state_nxt == ST_LG) && (r_state != ST_LG);

  // Next-state, blink phase and lamp decode; flash request overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_blink_nxt = r_blink;
    w_h_nxt     = r_h;
    w_l_nxt     = r_l;
    if (w_tick) begin
      if (FLASH && (r_state != ST_FL)) begin
        w_state_nxt = ST_FL;
      end else begin
        case (r_state)
          ST_HG:  if ((r_timer >= HG_LAST) && (LTV || r_ped_pend)) w_state_nxt = ST_HY;
          ST_HY:  if (r_timer >= Y_LAST)  w_state_nxt = ST_AR1;
          ST_AR1: if (r_timer >= AR_LAST) w_state_nxt = ST_LG;
          ST_LG:  if ((r_timer >= LGMAX_LAST) ||
                      ((r_timer >= LGMIN_LAST) && !LTV && w_walk_done))
                    w_state_nxt = ST_LY;
          ST_LY:  if (r_timer >= Y_LAST)  w_state_nxt = ST_AR2;
          ST_AR2: if (r_timer >= AR_LAST) w_state_nxt = ST_HG;
          ST_FL:  if (!FLASH)             w_state_nxt = ST_AR2;
          default:                        w_state_nxt = ST_HG;
        endcase
      end
      if (w_state_nxt == ST_FL)
        w_blink_nxt = (r_state == ST_FL) ? ~r_blink : 1'b1;
      case (w_state_nxt)
        ST_HG:   begin w_h_nxt = LAMP_G; w_l_nxt = LAMP_R; end
        ST_HY:   begin w_h_nxt = LAMP_Y; w_l_nxt = LAMP_R; end
        ST_LG:   begin w_h_nxt = LAMP_R; w_l_nxt = LAMP_G; end
        ST_LY:   begin w_h_nxt = LAMP_R; w_l_nxt = LAMP_Y; end
        ST_FL:   begin
          w_h_nxt = w_blink_nxt ? LAMP_Y : LAMP_OFF;
          w_l_nxt = w_blink_nxt ? LAMP_R : LAMP_OFF;
        end
        default: begin w_h_nxt = LAMP_R; w_l_nxt = LAMP_R; end
      endcase
    end
  end

  // State register and phase timer (restarts on every transition, saturates)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_HG;
      r_timer <= '0;
    end else if (w_tick) begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_timer <= '0;
      else if (r_timer != TMR_MAX) r_timer <= r_timer + CNT_W'(1);
    end
  end

  // Registered lamp outputs and flash blink phase
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_h     <= LAMP_G;
      r_l     <= LAMP_R;
      r_blink <= 1'b0;
    end else begin
      r_h     <= w_h_nxt;
      r_l     <= w_l_nxt;
      r_blink <= w_blink_nxt;
    end
  end

  // Pedestrian latch; a press coinciding with LG entry is served by that LG
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ped_pend   <= 1'b0;
      r_ped_served <= 1'b0;
    end else if (w_lg_entry) begin
      r_ped_pend   <= 1'b0;
      r_ped_served <= r_ped_pend | PED_REQ;
    end else if (PED_REQ) begin
      r_ped_pend   <= 1'b1;
    end
  end

  assign H     = r_h;
  assign L     = r_l;
  assign WALK  = w_walk;
  assign PHASE = r_state;
  assign TICK  = w_tick;

endmodule

// File: tb/tb_tlc_param_ctrl.sv
// Directed bench for tlc_param_ctrl with CLK_DIV=4 and default timings.
module tb_tlc_param_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       LTV = 1'b0;
  logic       PED_REQ = 1'b0;
  logic       FLASH = 1'b0;
  logic [2:0] H, L, PHASE;
  logic       WALK, TICK;

  int n_checks = 0;
  int n_errors = 0;
  int e = 0;  // CLK edges since the last reset release

  always #5 CLK = ~CLK;

  tlc_param_ctrl #(.CLK_DIV(4)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .LTV     (LTV),
    .PED_REQ (PED_REQ),
    .FLASH   (FLASH),
    .H       (H),
    .L       (L),
    .WALK    (WALK),
    .PHASE   (PHASE),
    .TICK    (TICK)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] ph, input logic [2:0] h,
                        input logic [2:0] l, input logic w);
    check({tag, ".phase"}, {5'd0, PHASE}, {5'd0, ph});
    check({tag, ".h"},     {5'd0, H},     {5'd0, h});
    check({tag, ".l"},     {5'd0, L},     {5'd0, l});
    check({tag, ".walk"},  {7'd0, WALK},  {7'd0, w});
  endtask

  // Advance to 1 time unit after release-relative edge t
  task automatic adv_to(input int t);
    while (e < t) begin
      @(posedge CLK);
      e++;
    end
    #1;
  endtask

  task automatic reset_dut(input string tag);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    chk_st({tag, ".rst"}, 3'd0, 3'b001, 3'b100, 1'b0);
    check({tag, ".rst.tick"}, {7'd0, TICK}, 8'd0);
    RST_N = 1'b1;
    e = 0;
  endtask

  // Lamp safety: highway not red means local must be red or dark
  always @(negedge CLK) begin
    if (H !== 3'b100) begin
      n_checks++;
      assert (L === 3'b100 || L === 3'b000) else begin
        n_errors++;
        $error("FAIL safety: observed H=%b L=%b required L=100 or 000", H, L);
      end
    end
  end

  initial begin
    // Idle: no demand, highway stays green, tick every 4 CLK
    reset_dut("s1");
    for (int i = 1; i <= 200; i++) begin
      adv_to(i);
      check("s1.h", {5'd0, H}, 8'h01);
      check("s1.l", {5'd0, L}, 8'h04);
      check("s1.tick", {7'd0, TICK}, (i % 4 == 3) ? 8'd1 : 8'd0);
    end

    // Continuous local vehicle: full cycle with LG held to max
    LTV = 1'b1;
    reset_dut("s2");
    adv_to(19); chk_st("s2.hg",   3'd0, 3'b001, 3'b100, 1'b0);
    adv_to(20); chk_st("s2.hy",   3'd1, 3'b010, 3'b100, 1'b0);
    adv_to(31); chk_st("s2.hy2",  3'd1, 3'b010, 3'b100, 1'b0);
    adv_to(32); chk_st("s2.ar1",  3'd2, 3'b100, 3'b100, 1'b0);
    adv_to(35); chk_st("s2.ar1b", 3'd2, 3'b100, 3'b100, 1'b0);
    adv_to(36); chk_st("s2.lg",   3'd3, 3'b100, 3'b001, 1'b0);
    adv_to(55); chk_st("s2.lg2",  3'd3, 3'b100, 3'b001, 1'b0);
    adv_to(56); chk_st("s2.ly",   3'd4, 3'b100, 3'b010, 1'b0);
    adv_to(67); chk_st("s2.ly2",  3'd4, 3'b100, 3'b010, 1'b0);
    adv_to(68); chk_st("s2.ar2",  3'd5, 3'b100, 3'b100, 1'b0);
    adv_to(71); chk_st("s2.ar2b", 3'd5, 3'b100, 3'b100, 1'b0);
    adv_to(72); chk_st("s2.hg2",  3'd0, 3'b001, 3'b100, 1'b0);

    // Short LTV pulse over HG-min tick: LG lasts only T_LG_MIN
    LTV = 1'b0;
    reset_dut("s3");
    adv_to(17); LTV = 1'b1;
    adv_to(19); chk_st("s3.hg",  3'd0, 3'b001, 3'b100, 1'b0);
    adv_to(20); chk_st("s3.hy",  3'd1, 3'b010, 3'b100, 1'b0);
    adv_to(21); LTV = 1'b0;
    adv_to(35); chk_st("s3.ar1", 3'd2, 3'b100, 3'b100, 1'b0);
    adv_to(36); chk_st("s3.lg",  3'd3, 3'b100, 3'b001, 1'b0);
    adv_to(43); chk_st("s3.lg2", 3'd3, 3'b100, 3'b001, 1'b0);
    adv_to(44); chk_st("s3.ly",  3'd4, 3'b100, 3'b010, 1'b0);
    adv_to(56); chk_st("s3.ar2", 3'd5, 3'b100, 3'b100, 1'b0);
    adv_to(60); chk_st("s3.hg2", 3'd0, 3'b001, 3'b100, 1'b0);

    // Single-cycle pedestrian press: served with WALK, latch cleared afterwards
    reset_dut("s4");
    adv_to(2); PED_REQ = 1'b1;
    adv_to(3); PED_REQ = 1'b0;
    adv_to(20); chk_st("s4.hy",   3'd1, 3'b010, 3'b100, 1'b0);
    adv_to(35); chk_st("s4.ar1",  3'd2, 3'b100, 3'b100, 1'b0);
    adv_to(36); chk_st("s4.lg",   3'd3, 3'b100, 3'b001, 1'b1);
    adv_to(51); chk_st("s4.lg2",  3'd3, 3'b100, 3'b001, 1'b1);
    adv_to(52); chk_st("s4.ly",   3'd4, 3'b100, 3'b010, 1'b0);
    adv_to(64); chk_st("s4.ar2",  3'd5, 3'b100, 3'b100, 1'b0);
    adv_to(68); chk_st("s4.hg",   3'd0, 3'b001, 3'b100, 1'b0);
    adv_to(88); chk_st("s4.hold", 3'd0, 3'b001, 3'b100, 1'b0);

    // Flash entered from LG, blinks per tick, exits through AR2
    LTV = 1'b1;
    reset_dut("s5");
    adv_to(36); chk_st("s5.lg",   3'd3, 3'b100, 3'b001, 1'b0);
    adv_to(38); FLASH = 1'b1;
    adv_to(39); chk_st("s5.lg2",  3'd3, 3'b100, 3'b001, 1'b0);
    adv_to(40); chk_st("s5.fl1",  3'd6, 3'b010, 3'b100, 1'b0);
    adv_to(43); chk_st("s5.fl1b", 3'd6, 3'b010, 3'b100, 1'b0);
    adv_to(44); chk_st("s5.fl0",  3'd6, 3'b000, 3'b000, 1'b0);
    adv_to(48); chk_st("s5.fl2",  3'd6, 3'b010, 3'b100, 1'b0);
    adv_to(49); FLASH = 1'b0;
    adv_to(52); chk_st("s5.ar2",  3'd5, 3'b100, 3'b100, 1'b0);
    adv_to(55); chk_st("s5.ar2b", 3'd5, 3'b100, 3'b100, 1'b0);
    adv_to(56); chk_st("s5.hg",   3'd0, 3'b001, 3'b100, 1'b0);

    // Asynchronous reset mid-LY, between clock edges
    reset_dut("s6");
    adv_to(58); chk_st("s6.ly", 3'd4, 3'b100, 3'b010, 1'b0);
    RST_N = 1'b0;
    #1;
    chk_st("s6.async", 3'd0, 3'b001, 3'b100, 1'b0);
    check("s6.async.tick", {7'd0, TICK}, 8'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    e = 0;
    adv_to(2);  check("s6.tick2", {7'd0, TICK}, 8'd0);
    adv_to(3);  check("s6.tick3", {7'd0, TICK}, 8'd1);
    adv_to(4);  check("s6.tick4", {7'd0, TICK}, 8'd0);
    adv_to(19); chk_st("s6.hg", 3'd0, 3'b001, 3'b100, 1'b0);
    adv_to(20); chk_st("s6.hy", 3'd1, 3'b010, 3'b100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
